// File: rtl/m10k_pass_ctrl_pkg.sv
// Shared types and defaults for the M10K pass sequencer.
package m10k_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Return FIFO holds every read that can be in the M10K pipe plus two words of slack.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/m10k_pass_ctrl_if.sv
// Source-read, PE and intermediate-write signals of the pass sequencer.
interface m10k_pass_ctrl_if
  import m10k_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                     src_rd_en;
  logic [ADDR_W-1:0]        src_rd_addr;
  logic signed [DATA_W-1:0] src_rd_data;
  logic                     pe_in_valid;
  logic signed [DATA_W-1:0] pe_in_data;
  logic                     pe_in_ready;
  logic                     pe_out_valid;
  logic signed [DATA_W-1:0] pe_out_data;
  logic                     int_wr_en;
  logic [ADDR_W-1:0]        int_wr_addr;
  logic signed [DATA_W-1:0] int_wr_data;

  modport master (
    output src_rd_en, src_rd_addr,
    input  src_rd_data,
    output pe_in_valid, pe_in_data,
    input  pe_in_ready, pe_out_valid, pe_out_data,
    output int_wr_en, int_wr_addr, int_wr_data
  );

  modport slave (
    input  src_rd_en, src_rd_addr,
    output src_rd_data,
    input  pe_in_valid, pe_in_data,
    output pe_in_ready, pe_out_valid, pe_out_data,
    input  int_wr_en, int_wr_addr, int_wr_data
  );

endinterface

// File: rtl/m10k_pass_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; head reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m10k_pass_ctrl.sv
// One compute pass: stream the source M10K through the PE into the intermediate M10K.
module m10k_pass_ctrl
  import m10k_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  m10k_pass_ctrl_if.master  bus
);

  localparam int unsigned FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  logic [ADDR_W:0]     rd_cnt;
  logic [ADDR_W:0]     wr_cnt;
  logic [RD_LAT-1:0]   vsr;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_W-1:0]   fifo_head;
  logic                credit;
  int unsigned         inflight;

  assign fifo_push       = vsr[RD_LAT-1];
  assign fifo_pop        = bus.pe_in_valid & bus.pe_in_ready;
  assign bus.pe_in_valid = ~fifo_empty;
  assign bus.pe_in_data  = fifo_head;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.src_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The read on src_rd_en this cycle is already committed, so it counts as in flight
  // when deciding whether the read for next cycle fits.
  always_comb begin
    inflight = 32'($countones(vsr)) + 32'(bus.src_rd_en);
    credit   = ~fifo_full &&
               ((32'(fifo_count) + inflight) < (FIFO_DEPTH + 32'(fifo_pop)));
  end

  always_ff @(posedge clk) begin
    if (reset) vsr <= '0;
    else       vsr <= (vsr << 1) | RD_LAT'(bus.src_rd_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      bus.src_rd_en   <= 1'b0;
      bus.src_rd_addr <= '0;
      bus.int_wr_en   <= 1'b0;
      bus.int_wr_addr <= '0;
      bus.int_wr_data <= '0;
    end else begin
      done          <= 1'b0;
      bus.int_wr_en <= 1'b0;

      if ((state == ISSUE || state == DRAIN) && bus.pe_out_valid &&
          wr_cnt < (ADDR_W+1)'(DEPTH)) begin
        bus.int_wr_en   <= 1'b1;
        bus.int_wr_addr <= wr_cnt[ADDR_W-1:0];
        bus.int_wr_data <= bus.pe_out_data;
        wr_cnt          <= wr_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state           <= ISSUE;
            busy            <= 1'b1;
            bus.src_rd_en   <= 1'b1;
            bus.src_rd_addr <= '0;
            rd_cnt          <= (ADDR_W+1)'(1);
            wr_cnt          <= '0;
          end
        end
        ISSUE: begin
          // rd_cnt counts reads issued including the one on the bus this cycle.
          if (rd_cnt == (ADDR_W+1)'(DEPTH)) begin
            state         <= DRAIN;
            bus.src_rd_en <= 1'b0;
          end else if (credit) begin
            bus.src_rd_en   <= 1'b1;
            bus.src_rd_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt          <= rd_cnt + 1'b1;
          end else begin
            bus.src_rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.int_wr_en && bus.int_wr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m10k_pass_ctrl.sv
// Directed bench for m10k_pass_ctrl: a 256-word RD_LAT=2 instance and a 4-word RD_LAT=1 instance.
module tb_m10k_pass_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: DEPTH=256, RD_LAT=2, identity PE latency 3
  logic reset_a = 1'b1, start_a = 1'b0, ready_a = 1'b1;
  logic busy_a, done_a;
  m10k_pass_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();

  m10k_pass_ctrl #(.DEPTH(256), .ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  logic signed [7:0] src_a [256];
  logic signed [7:0] int_a [256];
  logic signed [7:0] rdp_a [2];
  logic [1:0]        rvp_a = '0;
  logic [2:0]        pev_a = '0;
  logic signed [7:0] ped_a [3];

  assign bus_a.src_rd_data  = rdp_a[1];
  assign bus_a.pe_in_ready  = ready_a;
  assign bus_a.pe_out_valid = pev_a[2];
  assign bus_a.pe_out_data  = ped_a[2];

  always @(posedge clk) begin
    rdp_a[0] <= src_a[bus_a.src_rd_addr];
    rdp_a[1] <= rdp_a[0];
    rvp_a    <= {rvp_a[0], bus_a.src_rd_en};
    pev_a    <= {pev_a[1:0], bus_a.pe_in_valid & bus_a.pe_in_ready};
    ped_a[0] <= bus_a.pe_in_data;
    ped_a[1] <= ped_a[0];
    ped_a[2] <= ped_a[1];
    if (bus_a.int_wr_en === 1'b1) int_a[bus_a.int_wr_addr] <= bus_a.int_wr_data;
  end

  int cyc = 0;
  int n_iss, n_busy, n_done, n_wr, ret_cnt, pop_cnt, max_occ, done_cyc, last_wr_cyc, s_cyc;
  int iss_addr [512];
  int iss_cyc  [512];

  always @(posedge clk) begin
    if (bus_a.src_rd_en === 1'b1 && n_iss < 512) begin
      iss_addr[n_iss] = int'(bus_a.src_rd_addr);
      iss_cyc[n_iss]  = cyc;
      n_iss++;
    end
    if (busy_a === 1'b1) n_busy++;
    if (done_a === 1'b1) begin n_done++; done_cyc = cyc; end
    if (bus_a.int_wr_en === 1'b1) begin n_wr++; last_wr_cyc = cyc; end
    if (rvp_a[1]) ret_cnt++;
    if (bus_a.pe_in_valid === 1'b1 && bus_a.pe_in_ready === 1'b1) pop_cnt++;
    if (ret_cnt - pop_cnt > max_occ) max_occ = ret_cnt - pop_cnt;
    cyc++;
  end

  // ---------------- instance B: DEPTH=4, RD_LAT=1, negating PE latency 1
  logic reset_b = 1'b1, start_b = 1'b0;
  logic busy_b, done_b;
  m10k_pass_ctrl_if #(.ADDR_W(2), .DATA_W(8)) bus_b ();

  m10k_pass_ctrl #(.DEPTH(4), .ADDR_W(2), .DATA_W(8), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  logic signed [7:0] src_b [4];
  logic signed [7:0] int_b [4];
  logic signed [7:0] rdp_b;
  logic              pev_b = 1'b0;
  logic signed [7:0] ped_b;

  assign bus_b.src_rd_data  = rdp_b;
  assign bus_b.pe_in_ready  = 1'b1;
  assign bus_b.pe_out_valid = pev_b;
  assign bus_b.pe_out_data  = ped_b;

  int n_busy_b = 0, n_done_b = 0, n_wr_b = 0, done_cyc_b = 0, last_wr_cyc_b = 0;

  always @(posedge clk) begin
    rdp_b <= src_b[bus_b.src_rd_addr];
    pev_b <= bus_b.pe_in_valid & bus_b.pe_in_ready;
    ped_b <= -bus_b.pe_in_data;
    if (bus_b.int_wr_en === 1'b1) int_b[bus_b.int_wr_addr] <= bus_b.int_wr_data;
  end

  always @(posedge clk) begin
    if (busy_b === 1'b1) n_busy_b++;
    if (done_b === 1'b1) begin n_done_b++; done_cyc_b = cyc; end
    if (bus_b.int_wr_en === 1'b1) begin n_wr_b++; last_wr_cyc_b = cyc; end
  end

  // ---------------- helpers (stimulus only)
  function automatic logic bp_pat(input int c);
    case (c % 4)
      0: return 1'b1;
      1: return 1'b0;
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_a();
    n_iss = 0; n_busy = 0; n_done = 0; n_wr = 0;
    ret_cnt = 0; pop_cnt = 0; max_occ = 0; done_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic fill_random_a();
    for (int i = 0; i < 256; i++) src_a[i] = 8'($urandom_range(0, 255));
  endtask

  // Assert start this cycle and return at the falling edge of the cycle where done is seen.
  task automatic run_pass(input int restart_at, input bit bp, output bit ok);
    ok = 1'b0;
    clear_a();
    s_cyc   = cyc;
    start_a = 1'b1;
    ready_a = bp ? bp_pat(cyc) : 1'b1;
    for (int rel = 1; rel <= 3000; rel++) begin
      @(negedge clk);
      start_a = (rel == restart_at);
      ready_a = bp ? bp_pat(cyc) : 1'b1;
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    start_a = 1'b0;
    ready_a = 1'b1;
  endtask

  // ---------------- tests
  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (3) @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_a); end
    n_checks++; if (bus_a.src_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", bus_a.src_rd_en); end
    n_checks++; if (bus_a.src_rd_addr !== 8'd0) begin n_fail++; $display("FAIL reset_rd_addr got=%0d want=0", bus_a.src_rd_addr); end
    n_checks++; if (bus_a.pe_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pe_valid got=%b want=0", bus_a.pe_in_valid); end
    n_checks++; if (bus_a.pe_in_data !== 8'sd0) begin n_fail++; $display("FAIL reset_pe_data got=%0d want=0", bus_a.pe_in_data); end
    n_checks++; if (bus_a.int_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", bus_a.int_wr_en); end
    n_checks++; if (bus_a.int_wr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d want=0", bus_a.int_wr_addr); end
    n_checks++; if (bus_a.int_wr_data !== 8'sd0) begin n_fail++; $display("FAIL reset_wr_data got=%0d want=0", bus_a.int_wr_data); end
    n_checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_fail++; $display("FAIL reset_b busy=%b done=%b want=0,0", busy_b, done_b); end
  endtask

  task automatic test_full_throughput();
    bit ok;
    for (int i = 0; i < 256; i++) src_a[i] = 8'(i - 128);
    run_pass(-1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout done not seen within budget"); end
    @(negedge clk);
    n_checks++; if (n_iss !== 256) begin n_fail++; $display("FAIL full_issue_count got=%0d want=256", n_iss); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (iss_addr[k] !== k || iss_cyc[k] !== s_cyc + 1 + k) begin
        n_fail++; $display("FAIL full_issue[%0d] addr=%0d cyc=%0d want addr=%0d cyc=%0d", k, iss_addr[k], iss_cyc[k], k, s_cyc + 1 + k);
      end
    end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int'(int_a[i]) !== i - 128) begin n_fail++; $display("FAIL full_int[%0d] got=%0d want=%0d", i, int_a[i], i - 128); end
    end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL full_done_count got=%0d want=1", n_done); end
    n_checks++; if (n_busy !== 263) begin n_fail++; $display("FAIL full_busy_cycles got=%0d want=263", n_busy); end
    n_checks++; if (done_cyc !== last_wr_cyc + 1) begin n_fail++; $display("FAIL full_done_timing done=%0d want=%0d", done_cyc, last_wr_cyc + 1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    fill_random_a();
    run_pass(-1, 1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout done not seen within budget"); end
    @(negedge clk);
    n_checks++; if (max_occ > 4) begin n_fail++; $display("FAIL bp_fifo_occupancy got=%0d want<=4", max_occ); end
    n_checks++; if (n_wr !== 256) begin n_fail++; $display("FAIL bp_write_count got=%0d want=256", n_wr); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL bp_done_count got=%0d want=1", n_done); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int_a[i] !== src_a[i]) begin n_fail++; $display("FAIL bp_int[%0d] got=%0d want=%0d", i, int_a[i], src_a[i]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    bit ok;
    fill_random_a();
    run_pass(50, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout done not seen within budget"); end
    repeat (4) @(negedge clk);
    n_checks++; if (n_iss !== 256) begin n_fail++; $display("FAIL restart_issue_count got=%0d want=256", n_iss); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (iss_addr[k] !== k) begin n_fail++; $display("FAIL restart_issue[%0d] addr=%0d want=%0d", k, iss_addr[k], k); end
    end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL restart_done_count got=%0d want=1", n_done); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL restart_busy_after got=%b want=0", busy_a); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int_a[i] !== src_a[i]) begin n_fail++; $display("FAIL restart_int[%0d] got=%0d want=%0d", i, int_a[i], src_a[i]); end
    end
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    fill_random_a();
    clear_a();
    start_a = 1'b1;
    for (int rel = 1; rel <= 100; rel++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (rel == 100) reset_a = 1'b1;
    end
    @(negedge clk);
    reset_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || bus_a.src_rd_en !== 1'b0 || bus_a.src_rd_addr !== 8'd0 ||
        bus_a.pe_in_valid !== 1'b0 || bus_a.pe_in_data !== 8'sd0 || bus_a.int_wr_en !== 1'b0 ||
        bus_a.int_wr_addr !== 8'd0 || bus_a.int_wr_data !== 8'sd0) begin
      n_fail++;
      $display("FAIL midreset_outputs busy=%b done=%b rd_en=%b rd_addr=%0d pe_v=%b pe_d=%0d wr_en=%b wr_addr=%0d wr_d=%0d want all 0",
               busy_a, done_a, bus_a.src_rd_en, bus_a.src_rd_addr, bus_a.pe_in_valid, bus_a.pe_in_data,
               bus_a.int_wr_en, bus_a.int_wr_addr, bus_a.int_wr_data);
    end
    n_wr = 0;
    repeat (20) @(negedge clk);
    n_checks++; if (n_wr !== 0) begin n_fail++; $display("FAIL midreset_late_writes got=%0d want=0", n_wr); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b want=0", busy_a); end
    fill_random_a();
    run_pass(-1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_fresh_timeout done not seen within budget"); end
    @(negedge clk);
    n_checks++; if (n_iss !== 256 || iss_addr[0] !== 0 || iss_cyc[0] !== s_cyc + 1) begin
      n_fail++; $display("FAIL midreset_fresh_issue count=%0d addr0=%0d cyc0=%0d want 256,0,%0d", n_iss, iss_addr[0], iss_cyc[0], s_cyc + 1);
    end
    n_checks++; if (n_wr !== 256 || n_done !== 1) begin n_fail++; $display("FAIL midreset_fresh_counts wr=%0d done=%0d want 256,1", n_wr, n_done); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int_a[i] !== src_a[i]) begin n_fail++; $display("FAIL midreset_int[%0d] got=%0d want=%0d", i, int_a[i], src_a[i]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d1;
    fill_random_a();
    run_pass(-1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout done not seen within budget"); end
    @(negedge clk);
    d1 = done_cyc;
    n_checks++; if (n_done !== 1 || n_wr !== 256) begin n_fail++; $display("FAIL b2b_first_counts done=%0d wr=%0d want 1,256", n_done, n_wr); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int_a[i] !== src_a[i]) begin n_fail++; $display("FAIL b2b_first_int[%0d] got=%0d want=%0d", i, int_a[i], src_a[i]); end
    end
    fill_random_a();
    run_pass(-1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout done not seen within budget"); end
    @(negedge clk);
    n_checks++; if (iss_cyc[0] !== d1 + 2 || iss_addr[0] !== 0) begin
      n_fail++; $display("FAIL b2b_second_start cyc=%0d addr=%0d want cyc=%0d addr=0", iss_cyc[0], iss_addr[0], d1 + 2);
    end
    n_checks++; if (n_done !== 1 || n_wr !== 256) begin n_fail++; $display("FAIL b2b_second_counts done=%0d wr=%0d want 1,256", n_done, n_wr); end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (int_a[i] !== src_a[i]) begin n_fail++; $display("FAIL b2b_second_int[%0d] got=%0d want=%0d", i, int_a[i], src_a[i]); end
    end
  endtask

  task automatic test_rd_lat1_negate();
    int want [4];
    bit ok;
    want[0] = -7; want[1] = 8; want[2] = 0; want[3] = -127;
    src_b[0] = 8'sd7; src_b[1] = -8'sd8; src_b[2] = 8'sd0; src_b[3] = 8'sd127;
    n_busy_b = 0; n_done_b = 0; n_wr_b = 0;
    ok = 1'b0;
    start_b = 1'b1;
    for (int rel = 1; rel <= 100; rel++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b === 1'b1) begin ok = 1'b1; break; end
    end
    start_b = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lat1_timeout done not seen within budget"); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (int'(int_b[i]) !== want[i]) begin n_fail++; $display("FAIL lat1_int[%0d] got=%0d want=%0d", i, int_b[i], want[i]); end
    end
    n_checks++; if (done_cyc_b !== last_wr_cyc_b + 1) begin n_fail++; $display("FAIL lat1_done_timing done=%0d want=%0d", done_cyc_b, last_wr_cyc_b + 1); end
    n_checks++; if (n_done_b !== 1 || n_wr_b !== 4) begin n_fail++; $display("FAIL lat1_counts done=%0d wr=%0d want 1,4", n_done_b, n_wr_b); end
    n_checks++; if (n_busy_b !== 8) begin n_fail++; $display("FAIL lat1_busy_cycles got=%0d want=8", n_busy_b); end
  endtask

  initial begin
    clear_a();
    test_reset();
    test_full_throughput();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_pass();
    test_back_to_back();
    test_rd_lat1_negate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
